// File: rtl/boolexp_sweep_ctrl_if.sv
// boolexp_sweep_ctrl_if: connects a sweep controller to its start source and expression block
// master: drives start and y, observes the vector and results.
// slave: the controller; takes start and y, drives a,b,c,d, busy, done, tt, ones, pass, mismatch.
interface boolexp_sweep_ctrl_if;
  logic start, y, a, b, c, d, busy, done, pass;
  logic [15:0] tt, mismatch;
  logic [4:0] ones;
  modport master(output start, y, input a, b, c, d, busy, done, tt, ones, pass, mismatch);
  modport slave(input start, y, output a, b, c, d, busy, done, tt, ones, pass, mismatch);
endinterface

// File: rtl/boolexp_sweep_ctrl.sv
// boolexp_sweep_ctrl: drives all 16 {a,b,c,d} vectors onto an expression block and captures its truth table
// Ports: clk; rst_n (async, active-low); bus (slave modport): start, y in; a, b, c, d, busy, done, tt, ones, pass, mismatch out.
// Parameters: SETTLE (1..15) hold cycles before each sample; EXPECTED golden table, bit i = y for {a,b,c,d} = i.
// Define BOOLEXP_SWEEP_CHECK_EN to build the EXPECTED comparison; otherwise pass/mismatch are tied to 0.
module boolexp_sweep_ctrl #(
  parameter int SETTLE = 2,
  parameter logic [15:0] EXPECTED = 16'h0703
) (
  input logic clk,
  input logic rst_n,
  boolexp_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
  state_t state, next;
  logic [3:0] idx, cnt;
  logic [15:0] tt;
  logic [4:0] ones;
  logic go;
  assign go = state == IDLE && bus.start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.start ? DRIVE : IDLE;
      DRIVE: next = cnt == 4'(SETTLE - 1) ? SAMPLE : DRIVE;
      SAMPLE: next = idx == 4'hF ? DONE : DRIVE;
      default: next = IDLE;
    endcase
  end
  // idx doubles as the driven vector, so it stays at 4'hF after a sweep until the next start
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
      tt <= '0;
      ones <= '0;
    end else begin
      if (go) begin
        idx <= '0;
        cnt <= '0;
        tt <= '0;
        ones <= '0;
      end
      if (state == DRIVE) cnt <= cnt + 4'd1;
      if (state == SAMPLE) begin
        tt[idx] <= bus.y;
        ones <= ones + 5'(bus.y);
        cnt <= '0;
        idx <= idx == 4'hF ? idx : idx + 4'd1;
      end
    end
  assign {bus.a, bus.b, bus.c, bus.d} = idx;
  assign bus.busy = state == DRIVE || state == SAMPLE;
  assign bus.done = state == DONE;
  assign bus.tt = tt;
  assign bus.ones = ones;
`ifdef BOOLEXP_SWEEP_CHECK_EN
  logic pass;
  logic [15:0] mismatch;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pass <= 1'b0;
      mismatch <= '0;
    end else if (go) begin
      pass <= 1'b0;
      mismatch <= '0;
    end else if (state == DONE) begin
      pass <= tt == EXPECTED;
      mismatch <= tt ^ EXPECTED;
    end
  assign bus.pass = pass;
  assign bus.mismatch = mismatch;
`else
  assign bus.pass = 1'b0;
  assign bus.mismatch = '0;
`endif
endmodule
